// File: rtl/psum_collector_if.sv
// rtl/psum_collector_if.sv - psum input stream and result output stream of one column collector
interface psum_collector_if #(
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_WIDTH  = 32
);
    logic [PSUM_WIDTH-1:0] psum_i;
    logic                  psum_en_i;
    logic [ACC_WIDTH-1:0]  out_data_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic                  out_last_o;

    // Producer of partial sums and consumer of results
    modport master (
        output psum_i, psum_en_i, out_ready_i,
        input  out_data_o, out_valid_o, out_last_o
    );

    // The collector itself
    modport slave (
        input  psum_i, psum_en_i, out_ready_i,
        output out_data_o, out_valid_o, out_last_o
    );
endinterface

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - per-column partial-sum accumulator and drain (optional PSUM_COLLECTOR_SAT_EN: saturating add, sat_o)
module psum_collector #(
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int MAX_ROWS   = 16,
    parameter int MAX_TILES  = 16,
    localparam int RW        = $clog2(MAX_ROWS),
    localparam int TW        = $clog2(MAX_TILES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [RW-1:0]       num_rows_m1_i,
    input  logic [TW-1:0]       num_tiles_m1_i,
    psum_collector_if.slave     col,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
`ifdef PSUM_COLLECTOR_SAT_EN
    ,
    output logic                sat_o
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [RW-1:0]        rows_m1;
    logic [RW-1:0]        row_ptr;
    logic [RW-1:0]        rd_ptr;
    logic [TW-1:0]        tiles_m1;
    logic [TW-1:0]        tile_ptr;
    logic [ACC_WIDTH-1:0] acc [MAX_ROWS];

    logic                 start_acc;
    logic                 beat;
    logic                 beat_err;
    logic                 row_last;
    logic                 tile_last;
    logic                 rd_fire;
    logic                 rd_last;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH-1:0] psum_ext;
    logic [ACC_WIDTH-1:0] acc_wr;

    assign start_acc = start_i && (state == S_IDLE);
    assign beat      = col.psum_en_i && (state == S_ACCUM);
    assign beat_err  = col.psum_en_i && (state != S_ACCUM);
    assign row_last  = (row_ptr == rows_m1);
    assign tile_last = (tile_ptr == tiles_m1);
    assign rd_last   = (rd_ptr == rows_m1);
    assign rd_fire   = (state == S_DRAIN) && col.out_ready_i;

    // The first tile overwrites whatever a previous job left in the bank
    assign acc_base  = (tile_ptr == '0) ? '0 : acc[row_ptr];
    assign psum_ext  = ACC_WIDTH'(col.psum_i);

`ifdef PSUM_COLLECTOR_SAT_EN
    logic [ACC_WIDTH:0]   sum_full;
    logic                 sat_hit;

    assign sum_full = {1'b0, acc_base} + {1'b0, psum_ext};
    assign sat_hit  = sum_full[ACC_WIDTH];
    assign acc_wr   = sat_hit ? '1 : sum_full[ACC_WIDTH-1:0];
`else
    assign acc_wr   = acc_base + psum_ext;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: IDLE -> ACCUM on start, ACCUM -> DRAIN on final beat, DRAIN -> IDLE on last accepted row
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_ACCUM;
            S_ACCUM: if (beat && row_last && tile_last) state_nxt = S_DRAIN;
            S_DRAIN: if (rd_fire && rd_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state; data forced to zero outside DRAIN
    always_comb begin
        col.out_valid_o = 1'b0;
        col.out_last_o  = 1'b0;
        col.out_data_o  = '0;
        busy_o          = (state != S_IDLE);
        if (state == S_DRAIN) begin
            col.out_valid_o = 1'b1;
            col.out_last_o  = rd_last;
            col.out_data_o  = acc[rd_ptr];
        end
    end

    // Job configuration, pointers and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_m1  <= '0;
            tiles_m1 <= '0;
            row_ptr  <= '0;
            tile_ptr <= '0;
            rd_ptr   <= '0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            done_o <= rd_fire && rd_last;
            if (start_acc) begin
                rows_m1  <= num_rows_m1_i;
                tiles_m1 <= num_tiles_m1_i;
                row_ptr  <= '0;
                tile_ptr <= '0;
                rd_ptr   <= '0;
            end else if (beat) begin
                if (row_last) begin
                    row_ptr  <= '0;
                    tile_ptr <= tile_ptr + TW'(1);
                end else begin
                    row_ptr  <= row_ptr + RW'(1);
                end
            end
            if (rd_fire) rd_ptr <= rd_last ? '0 : rd_ptr + RW'(1);
            // A stray beat in the same cycle as an accepted start still flags the error
            if (beat_err)       err_o <= 1'b1;
            else if (start_acc) err_o <= 1'b0;
        end
    end

    // Accumulator bank: one write per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_ROWS; i++) acc[i] <= '0;
        end else if (beat) begin
            acc[row_ptr] <= acc_wr;
        end
    end

`ifdef PSUM_COLLECTOR_SAT_EN
    // Sticky saturation flag, cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               sat_o <= 1'b0;
        else if (beat && sat_hit) sat_o <= 1'b1;
        else if (start_acc)       sat_o <= 1'b0;
    end
`endif
endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sink at the bottom of one systolic-array column. Consumes the psum_o / psum_en_o stream leaving the last PE row.
- Accumulates partial sums across K-tiles into a per-row accumulator bank.
- Drains the finished column results to the output buffer over a valid/ready handshake.
- One instance per array column.

Parameters:
- PSUM_WIDTH, 32, width of the incoming partial sum.
- ACC_WIDTH, 32, accumulator and output width; must be >= PSUM_WIDTH, and psum is zero-extended.
- MAX_ROWS, 16, accumulator depth (output rows per tile); power of two.
- MAX_TILES, 16, maximum K-tiles per job; power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  job start pulse; accepted only in IDLE
- num_rows_m1_i  in  clog2(MAX_ROWS)  rows per tile minus 1; latched on start
- num_tiles_m1_i  in  clog2(MAX_TILES)  tiles per job minus 1; latched on start
- psum_i  in  PSUM_WIDTH  partial sum from the last PE row
- psum_en_i  in  1  psum_i valid this cycle; no backpressure is possible
- out_data_o  out  ACC_WIDTH  accumulated result
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  downstream accepts
- out_last_o  out  1  final row of the job; qualified by out_valid_o
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse after the last row is accepted
- err_o  out  1  sticky: psum_en_i seen outside ACCUM; cleared on accepted start

Behaviour:
- Reset values:
  - out_valid_o, out_last_o, busy_o, done_o, err_o = 0.
  - out_data_o = 0; the accumulator bank and all pointers are cleared.
  - State = IDLE.
- FSM is IDLE -> ACCUM -> DRAIN -> IDLE.
- IDLE:
  - start_i=1: latch num_rows_m1 / num_tiles_m1, clear row_ptr, tile_ptr, rd_ptr and err_o, then go to ACCUM next cycle.
  - psum_en_i=1: beat is dropped and err_o is set (a set takes priority over a clear in the same cycle).
- ACCUM, on each psum_en_i=1 cycle:
  - If tile_ptr==0: acc[row_ptr] <= psum_i. Otherwise acc[row_ptr] <= acc[row_ptr] + psum_i.
  - The write is visible on the next clock edge. Back-to-back beats every cycle are supported.
  - row_ptr increments. At row_ptr==num_rows_m1 it wraps to 0 and tile_ptr increments.
  - The beat with row_ptr==num_rows_m1 and tile_ptr==num_tiles_m1 moves the FSM to DRAIN next cycle.
  - psum_en_i=0 holds all state. Gaps of any length are allowed.
- Arithmetic: unsigned, wrap modulo 2^ACC_WIDTH (see the optional feature for the alternative).
- DRAIN:
  - out_valid_o=1 from the first DRAIN cycle. out_data_o = acc[rd_ptr].
  - out_last_o = (rd_ptr==num_rows_m1).
  - Data holds stable while valid && !ready.
  - On valid && ready: rd_ptr increments. If last, go to IDLE next cycle, with done_o=1 in that first IDLE cycle and out_valid_o=0.
  - psum_en_i=1 here: dropped, err_o set.
- start_i while busy_o=1 is ignored; latched config is unchanged.
- Latency:
  - Last ACCUM beat to first out_valid_o: 1 cycle.
  - Throughput: 1 row/cycle with out_ready_i held high.
- Single-row / single-tile case (num_rows_m1=0, num_tiles_m1=0) is legal: one beat, then one output with out_last_o=1.
- Reset mid-operation (rst_n low in any state): immediate return to reset values. The partially accumulated job is discarded.

Optional Feature:
- Macro: PSUM_COLLECTOR_SAT_EN.
- Defined: accumulation is unsigned saturating. If acc + zero-extended psum_i exceeds 2^ACC_WIDTH-1, the stored value is all ones and the sticky sat_o (extra 1-bit output, reset 0, cleared on accepted start) is set.
- Undefined: wrap-around modulo 2^ACC_WIDTH; the sat_o port does not exist.

Test Plan:
- Basic job: rows_m1=3, tiles_m1=0, beats 1,2,3,4 on consecutive cycles, ready=1 -> out 1,2,3,4; out_last_o on 4; done_o pulse; busy_o falls.
- Multi-tile: rows_m1=1, tiles_m1=2, beats 10,20 / 5,6 / 1,1 with idle gaps -> out 16,27.
- Backpressure: 4-row drain, ready toggling 1,0,0,1,0,1,1 -> each value held stable while stalled; order 0..3 preserved; no duplicates.
- Error and ignore: psum_en_i=1 in IDLE -> err_o=1, accumulator untouched; then start_i twice during ACCUM with different config -> second start ignored; err_o clears only on the accepted start.
- Overflow: ACC_WIDTH=32, tiles_m1=1, beats 0xFFFF_FFF0 then 0x20:
  - without the macro -> out 0x10;
  - with PSUM_COLLECTOR_SAT_EN -> out 0xFFFF_FFFF and sat_o=1.
- Reset mid-job: assert rst_n=0 after 2 of 4 beats -> all outputs 0; then a fresh job with rows_m1=1, beats 7,8 -> out 7,8 with no residue.
